// File: rtl/ssg_write_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ssg_ctrl_pkg                                                     |
// | Shared types, default sizes and a nibble helper for the seven-segment      |
// | write sequencer.                                                           |
// | Contents: state_t (sequencer states), NDIG_DEF/SELW_DEF/DIGW_DEF,          |
// |           get_nib() nibble extractor.                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ssg_ctrl_pkg;

   localparam int NDIG_DEF = 8;
   localparam int SELW_DEF = 3;
   localparam int DIGW_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Returns nibble k of a packed display value (nibble 0 = least significant).
   function automatic logic [DIGW_DEF-1:0] get_nib(
      input logic [NDIG_DEF*DIGW_DEF-1:0] value,
      input logic [SELW_DEF-1:0]          k
   );
      return value[int'(k)*DIGW_DEF +: DIGW_DEF];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ssg_write_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : ssg_write_ctrl_if                                              |
// | Requester-side handshake and display-side digit-write port bundled         |
// | together.                                                                  |
// | Signals : i_w_req, i_w_val0, i_w_val1 (requesters -> controller)           |
// |           o_w_gnt, o_w_done, o_w_busy (controller -> requesters)           |
// |           o_w_sel, o_w_dig, o_w_we    (controller -> display)              |
// | Modports: slave (controller), master (requesters/display/environment).     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface ssg_write_ctrl_if
   import ssg_ctrl_pkg::*;
#(
   parameter int NDIG = NDIG_DEF,
   parameter int SELW = SELW_DEF,
   parameter int DIGW = DIGW_DEF
);
   logic [1:0]           i_w_req;
   logic [NDIG*DIGW-1:0] i_w_val0;
   logic [NDIG*DIGW-1:0] i_w_val1;
   logic [1:0]           o_w_gnt;
   logic [1:0]           o_w_done;
   logic                 o_w_busy;
   logic [SELW-1:0]      o_w_sel;
   logic [DIGW-1:0]      o_w_dig;
   logic                 o_w_we;

   modport slave (
      input  i_w_req, i_w_val0, i_w_val1,
      output o_w_gnt, o_w_done, o_w_busy, o_w_sel, o_w_dig, o_w_we
   );

   modport master (
      output i_w_req, i_w_val0, i_w_val1,
      input  o_w_gnt, o_w_done, o_w_busy, o_w_sel, o_w_dig, o_w_we
   );
endinterface
`default_nettype wire

// File: rtl/ssg_write_ctrl_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arb2                                                           |
// | Two-input round-robin arbiter. Grant is combinational; the 1-bit priority  |
// | pointer is registered and moves to the other requester on each advance.    |
// | Ports : clk, rst_n (sync, active-low), req[1:0], adv (grant taken),        |
// |         gnt[1:0] (one-hot or zero).                                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic ptr;   // preferred requester when both request

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

   // After a grant to requester 0 the pointer prefers 1, and vice versa.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (adv && (gnt != 2'b00)) begin
         ptr <= gnt[0];
      end
   end
endmodule
`default_nettype wire

// File: rtl/ssg_write_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ssg_write_ctrl                                                    |
// | Arbitrates two requesters and writes the winner's 8-nibble value to the    |
// | display, one digit per cycle, least-significant first. Optionally skips    |
// | the write enable for digits that already hold the same value.             |
// | Ports : i_w_clk, i_w_reset (sync, active-low), bus (ssg_write_ctrl_if      |
// |         slave: req/val in, gnt/done/busy/sel/dig/we out).                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ssg_write_ctrl
   import ssg_ctrl_pkg::*;
#(
   parameter int NDIG      = NDIG_DEF,
   parameter int SELW      = SELW_DEF,
   parameter int DIGW      = DIGW_DEF,
   parameter int SKIP_SAME = 1
) (
   input  logic            i_w_clk,
   input  logic            i_w_reset,
   ssg_write_ctrl_if.slave bus
);
   state_t               state;
   state_t               state_nx;
   logic [SELW-1:0]      idx;
   logic [NDIG*DIGW-1:0] shreg;       // captured value, shifted down one nibble per write
   logic [NDIG*DIGW-1:0] shadow;      // copy of what the display currently holds
   logic                 shadow_vld;
   logic                 owner;       // index of the requester being served
   logic [1:0]           arb_gnt;
   logic                 arb_adv;
   logic [DIGW-1:0]      cur_nib;
   logic                 same_nib;
   logic                 write_en;

   logic [1:0]           gnt_reg;
   logic [1:0]           done_reg;
   logic                 busy_reg;
   logic [SELW-1:0]      sel_reg;
   logic [DIGW-1:0]      dig_reg;
   logic                 we_reg;

   assign arb_adv = (state == ST_IDLE) && (bus.i_w_req != 2'b00);

   rr_arb2 u_arb (
      .clk   (i_w_clk),
      .rst_n (i_w_reset),
      .req   (bus.i_w_req),
      .adv   (arb_adv),
      .gnt   (arb_gnt)
   );

   always_comb begin
      state_nx = state;
      cur_nib  = shreg[DIGW-1:0];
      same_nib = (SKIP_SAME != 0) && shadow_vld && (get_nib(shadow, idx) == cur_nib);
      write_en = (state == ST_WRITE) && !same_nib;
      case (state)
         ST_IDLE:  if (bus.i_w_req != 2'b00) state_nx = ST_WRITE;
         ST_WRITE: if (idx == SELW'(NDIG-1)) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_w_clk) begin
      if (!i_w_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge i_w_clk) begin
      if (!i_w_reset) begin
         idx        <= '0;
         shreg      <= '0;
         shadow     <= '0;
         shadow_vld <= 1'b0;
         owner      <= 1'b0;
         gnt_reg    <= '0;
         done_reg   <= '0;
         busy_reg   <= 1'b0;
         sel_reg    <= '0;
         dig_reg    <= '0;
         we_reg     <= 1'b0;
      end else begin
         gnt_reg  <= '0;
         done_reg <= '0;
         we_reg   <= 1'b0;
         // Busy trails the state by one cycle: covers the write and done cycles.
         busy_reg <= (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (bus.i_w_req != 2'b00) begin
                  gnt_reg <= arb_gnt;
                  owner   <= arb_gnt[1];
                  shreg   <= arb_gnt[1] ? bus.i_w_val1 : bus.i_w_val0;
                  idx     <= '0;
               end
            end
            ST_WRITE: begin
               sel_reg <= idx;
               dig_reg <= cur_nib;
               we_reg  <= write_en;
               if (write_en) begin
                  shadow[int'(idx)*DIGW +: DIGW] <= cur_nib;
               end
               shreg <= shreg >> DIGW;
               idx   <= idx + 1'b1;
            end
            ST_DONE: begin
               done_reg   <= owner ? 2'b10 : 2'b01;
               shadow_vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_w_gnt  = gnt_reg;
   assign bus.o_w_done = done_reg;
   assign bus.o_w_busy = busy_reg;
   assign bus.o_w_sel  = sel_reg;
   assign bus.o_w_dig  = dig_reg;
   assign bus.o_w_we   = we_reg;
endmodule
`default_nettype wire

// File: tb/tb_ssg_write_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : tb_ssg_write_ctrl                                                 |
// | Self-checking bench for ssg_write_ctrl. Keeps a per-digit model of the     |
// | display contents and the round-robin preference.                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ssg_write_ctrl;
   localparam int SKIP = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssg_write_ctrl_if #(.NDIG(8), .SELW(3), .DIGW(4)) bus ();

   ssg_write_ctrl #(.NDIG(8), .SELW(3), .DIGW(4), .SKIP_SAME(SKIP)) dut (
      .i_w_clk   (clk),
      .i_w_reset (rst_n),
      .bus       (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: what each display digit holds, whether that is known, and who is preferred.
   logic [3:0] sh [8];
   logic       sh_valid;
   logic       ptr_m;

   function automatic logic [12:0] outs();
      return {bus.o_w_gnt, bus.o_w_done, bus.o_w_busy, bus.o_w_sel, bus.o_w_dig, bus.o_w_we};
   endfunction

   function automatic logic [5:0] ctl();
      return {bus.o_w_gnt, bus.o_w_done, bus.o_w_busy, bus.o_w_we};
   endfunction

   function automatic logic [1:0] winner(input logic [1:0] r);
      if (r == 2'b11) return ptr_m ? 2'b10 : 2'b01;
      return r;
   endfunction

   // New value: each digit either kept from the display model or randomised.
   function automatic logic [31:0] derive();
      logic [31:0] v;
      for (int k = 0; k < 8; k++) begin
         v[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : sh[k];
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) sh[k] = 4'h0;
      sh_valid = 1'b0;
      ptr_m    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.i_w_req = 2'b00;
      repeat (2) step();
      rst_n = 1'b1;
      model_reset();
      step();
   endtask

   // Follows one update from the cycle after the grant through the done cycle.
   // Optional request changes e1/e2 are applied after write k checks.
   task automatic run_update(input string tag, input logic who, input logic [31:0] v,
                             input int e1k, input logic [1:0] e1r,
                             input int e2k, input logic [1:0] e2r);
      logic [3:0]  nib;
      logic        we_e;
      logic [12:0] exp;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) begin
            if (who) bus.i_w_val1 = $urandom;
            else     bus.i_w_val0 = $urandom;
         end
         nib  = v[k*4 +: 4];
         we_e = !((SKIP != 0) && sh_valid && (sh[k] == nib));
         exp  = {2'b00, 2'b00, 1'b1, 3'(k), nib, we_e};
         total++;
         if (outs() !== exp) begin
            bad++;
            $display("FAIL %s write k=%0d got=%h want=%h", tag, k, outs(), exp);
         end
         if (we_e) sh[k] = nib;
         if (k == e1k) bus.i_w_req = e1r;
         if (k == e2k) bus.i_w_req = e2r;
      end
      step();
      if (who) bus.i_w_val1 = v;
      else     bus.i_w_val0 = v;
      exp = {2'b00, (who ? 2'b10 : 2'b01), 1'b1, 3'd7, v[31:28], 1'b0};
      total++;
      if (outs() !== exp) begin
         bad++;
         $display("FAIL %s done got=%h want=%h", tag, outs(), exp);
      end
      sh_valid = 1'b1;
   endtask

   task automatic test_reset();
      bus.i_w_req  = 2'b00;
      bus.i_w_val0 = '0;
      bus.i_w_val1 = '0;
      rst_n = 1'b0;
      repeat (3) step();
      total++;
      if (outs() !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=%h", outs(), 13'd0);
      end
      rst_n = 1'b1;
      model_reset();
      step();
      total++;
      if (outs() !== 13'd0) begin
         bad++;
         $display("FAIL reset_idle got=%h want=%h", outs(), 13'd0);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.i_w_val0 = 32'h7654_3210;
      bus.i_w_req  = 2'b01;
      step();
      total++;
      if (ctl() !== 6'b01_00_0_0) begin
         bad++;
         $display("FAIL single_gnt got=%b want=%b", ctl(), 6'b01_00_0_0);
      end
      bus.i_w_req = 2'b00;
      ptr_m = 1'b1;
      run_update("single", 1'b0, 32'h7654_3210, -1, 2'b00, -1, 2'b00);
      step();
      total++;
      if (ctl() !== 6'd0) begin
         bad++;
         $display("FAIL single_idle got=%b want=%b", ctl(), 6'd0);
      end
   endtask

   task automatic test_alternate();
      logic [1:0] w;
      do_reset();
      bus.i_w_val0 = 32'h1111_1111;
      bus.i_w_val1 = 32'h2222_2222;
      bus.i_w_req  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         w = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
         total++;
         if (ctl() !== {w, 4'b0000}) begin
            bad++;
            $display("FAIL alt_gnt i=%0d got=%b want=%b", i, ctl(), {w, 4'b0000});
         end
         ptr_m = w[0];
         run_update("alternate", w[1], w[1] ? 32'h2222_2222 : 32'h1111_1111,
                    -1, 2'b00, -1, 2'b00);
      end
      bus.i_w_req = 2'b00;
      step();
      total++;
      if (ctl() !== 6'd0) begin
         bad++;
         $display("FAIL alt_stop got=%b want=%b", ctl(), 6'd0);
      end
   endtask

   task automatic test_skip();
      logic [31:0] vals [2];
      vals[0] = 32'h7654_3210;
      vals[1] = 32'h7654_3A10;
      for (int i = 0; i < 2; i++) begin
         bus.i_w_val0 = vals[i];
         bus.i_w_req  = 2'b01;
         step();
         total++;
         if (ctl() !== 6'b01_00_0_0) begin
            bad++;
            $display("FAIL skip_gnt i=%0d got=%b want=%b", i, ctl(), 6'b01_00_0_0);
         end
         bus.i_w_req = 2'b00;
         ptr_m = 1'b1;
         run_update("skip", 1'b0, vals[i], -1, 2'b00, -1, 2'b00);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0]  nib;
      logic        we_e;
      logic [31:0] v;
      v = 32'h7654_3210;
      bus.i_w_val1 = v;
      bus.i_w_req  = 2'b10;
      step();
      total++;
      if (ctl() !== 6'b10_00_0_0) begin
         bad++;
         $display("FAIL rmid_gnt got=%b want=%b", ctl(), 6'b10_00_0_0);
      end
      bus.i_w_req = 2'b00;
      ptr_m = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         nib  = v[k*4 +: 4];
         we_e = !((SKIP != 0) && sh_valid && (sh[k] == nib));
         total++;
         if (outs() !== {5'b00_00_1, 3'(k), nib, we_e}) begin
            bad++;
            $display("FAIL rmid_write k=%0d got=%h want=%h", k, outs(), {5'b00_00_1, 3'(k), nib, we_e});
         end
         if (we_e) sh[k] = nib;
      end
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (outs() !== 13'd0) begin
            bad++;
            $display("FAIL rmid_reset i=%0d got=%h want=%h", i, outs(), 13'd0);
         end
      end
      rst_n = 1'b1;
      model_reset();
      step();
      total++;
      if (outs() !== 13'd0) begin
         bad++;
         $display("FAIL rmid_after got=%h want=%h", outs(), 13'd0);
      end
      bus.i_w_val0 = v;
      bus.i_w_req  = 2'b01;
      step();
      total++;
      if (ctl() !== 6'b01_00_0_0) begin
         bad++;
         $display("FAIL rmid_regnt got=%b want=%b", ctl(), 6'b01_00_0_0);
      end
      bus.i_w_req = 2'b00;
      ptr_m = 1'b1;
      run_update("rmid_rewrite", 1'b0, v, -1, 2'b00, -1, 2'b00);
   endtask

   task automatic test_mid_request();
      logic [31:0] v0;
      logic [31:0] v1;
      step();
      v0 = derive();
      v1 = derive();
      bus.i_w_val0 = v0;
      bus.i_w_val1 = v1;
      bus.i_w_req  = 2'b01;
      step();
      total++;
      if (ctl() !== 6'b01_00_0_0) begin
         bad++;
         $display("FAIL mid_gnt0 got=%b want=%b", ctl(), 6'b01_00_0_0);
      end
      bus.i_w_req = 2'b00;
      ptr_m = 1'b1;
      // Requester 1 raises its request during the write and holds it.
      run_update("mid_first", 1'b0, v0, 3, 2'b10, -1, 2'b00);
      step();
      total++;
      if (ctl() !== 6'b10_00_0_0) begin
         bad++;
         $display("FAIL mid_gnt1 got=%b want=%b", ctl(), 6'b10_00_0_0);
      end
      bus.i_w_req = 2'b00;
      ptr_m = 1'b0;
      // Requester 0 raises and drops its request before the controller is idle.
      run_update("mid_second", 1'b1, v1, 2, 2'b01, 5, 2'b00);
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if (ctl() !== 6'd0) begin
            bad++;
            $display("FAIL mid_dropped i=%0d got=%b want=%b", i, ctl(), 6'd0);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  req_now;
      logic [1:0]  w;
      logic [31:0] v;
      req_now = 2'b00;
      for (int it = 0; it < 10; it++) begin
         if (req_now == 2'b00) begin
            req_now      = 2'($urandom_range(1, 3));
            bus.i_w_val0 = derive();
            bus.i_w_val1 = derive();
            bus.i_w_req  = req_now;
         end
         w = winner(req_now);
         step();
         total++;
         if (ctl() !== {w, 4'b0000}) begin
            bad++;
            $display("FAIL rand_gnt it=%0d got=%b want=%b", it, ctl(), {w, 4'b0000});
         end
         ptr_m       = w[0];
         req_now     = req_now & ~w;
         bus.i_w_req = req_now;
         v = w[1] ? bus.i_w_val1 : bus.i_w_val0;
         run_update("random", w[1], v, -1, 2'b00, -1, 2'b00);
      end
      bus.i_w_req = 2'b00;
      step();
      total++;
      if (ctl() !== 6'd0) begin
         bad++;
         $display("FAIL rand_idle got=%b want=%b", ctl(), 6'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_skip();
      test_reset_mid();
      test_mid_request();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ssg_write_ctrl.md
# ssg_write_ctrl

Write sequencer and two-requester arbiter for the 8-digit sequential seven-segment display block. It accepts 32-bit (8 hex-nibble) display values from two independent requesters, grants one at a time round-robin, and drives the display's digit-write port (select, digit, write enable) over eight consecutive cycles, least-significant nibble first. Sits directly in front of the display's write port; the display's own scan/multiplex logic is untouched.

## Interface
- NDIG, 8: digits per update, one per write cycle
- SELW, 3: digit-select width, log2(NDIG)
- DIGW, 4: digit value width
- SKIP_SAME, 1: when 1, suppress the write enable for digits equal to the last value written
- i_w_clk  in  1  clock; all logic on the rising edge
- i_w_reset  in  1  reset, synchronous, active-low
- i_w_req  in  2  per-requester request; held high until granted
- i_w_val0  in  NDIG*DIGW  requester 0 value; nibble k goes to digit k
- i_w_val1  in  NDIG*DIGW  requester 1 value
- o_w_gnt  out  2  one-hot, one-cycle grant pulse; value sampled on this cycle
- o_w_done  out  2  one-hot, one-cycle completion pulse to the granted requester
- o_w_busy  out  1  high from the cycle after a grant through the done cycle
- o_w_sel  out  SELW  digit select to the display
- o_w_dig  out  DIGW  digit value to the display
- o_w_we  out  1  write enable to the display

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: arbitrate on i_w_req. On any request, pulse o_w_gnt for the winner, capture its value into the shift register, clear index, and go to WRITE.
- Round-robin: a 1-bit priority pointer names the preferred requester. If both request, the preferred one wins. After every grant the pointer points to the other requester. Pointer resets to requester 0.
- WRITE: for index k = 0..NDIG-1, one per cycle:
  - o_w_sel = k; o_w_dig = nibble k of the captured value.
  - o_w_we = 1, except when SKIP_SAME=1, the shadow is valid, and shadow nibble k equals the new nibble; then o_w_we = 0.
  - On every cycle with o_w_we = 1, the shadow nibble is updated.
  - After k = NDIG-1, go to DONE.
- DONE: pulse o_w_done for the granted requester, set shadow-valid, return to IDLE.
- Requests are evaluated only in IDLE. Requests during WRITE/DONE are neither queued nor lost; a held request is served at the next IDLE.
- A request dropped before its grant is never granted.
- Changes on i_w_val* after the grant have no effect.
- Shadow-valid clears on reset, so the first update after reset writes all NDIG digits regardless of SKIP_SAME.

## Timing
- All outputs are registered. Reset value of every output is 0: gnt, done, busy, sel, dig, we.
- Reset also sets state IDLE, pointer 0, shadow 0, shadow-valid 0.
- Grant on cycle t:
  - write cycles t+1..t+8 (sel 0..7)
  - o_w_busy high t+1..t+9
  - o_w_done on t+9
  - IDLE on t+10, earliest next grant t+10
- Fixed 10-cycle period per update; SKIP_SAME does not shorten it.
- Reset asserted mid-WRITE: next edge forces all outputs to 0 and state IDLE, with no done pulse. Digits already written stay on the display. The interrupted requester must re-request.
- Grant and done never overlap; o_w_gnt and o_w_done are each at most one-hot.

## Structure
- Package ssg_ctrl_pkg holds:
  - state enum (IDLE, WRITE, DONE)
  - NDIG/SELW/DIGW defaults
  - a nibble-extract function
- One sub-module, rr_arb2: two-input round-robin arbiter with priority pointer and an advance strobe. Combinational grant, registered pointer.
- Shift/index register, shadow register, and FSM stay in ssg_write_ctrl.

## Test plan
- Reset then single request: i_w_req=01, val0=0x76543210 → gnt=01 at t; writes sel 0..7 with dig 0..7 on t+1..t+8, we=1 each; done=01 at t+9.
- Both requesting continuously, val0=0x11111111, val1=0x22222222 → grants alternate 0,1,0,1, starting with requester 0; grants spaced 10 cycles apart.
- SKIP_SAME=1, after an update with 0x76543210 → request 0x76543A10: we=1 only at sel=2 (dig=A); done still at t+9.
- Reset asserted at sel=4 → next cycle all outputs 0 and no done pulse. A re-request of 0x76543210 then writes all 8 digits (shadow invalid).
- Request raised mid-WRITE by requester 1 and held → granted at the first IDLE cycle (t+10), not earlier. A request dropped before that cycle → never granted.
